fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and drives a synchronous-read instruction memory.
- Presents pc/inst/valid to decode.
- Handles redirects from decode (j/jal/jr) and execute (taken branch), backpressure stall, start and halt.

---
 rtl/fetch_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage feeding decode.
//
// Owns the program counter and drives a synchronous-read instruction memory
// (data returns one cycle after the read is issued). A one-entry skid
// register keeps the presented instruction stable while decode stalls.
// Redirects come from decode (jumps) and from execute (taken branches).
//
// Parameters:
//   RESET_PC  byte address fetched first after start
//   IMEM_AW   instruction-memory word-address width
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               leave IDLE and begin fetching
//   stall               decode cannot accept the presented instruction
//   dec_redirect/npc    decode-resolved jump and its target
//   ex_redirect/target  execute-resolved taken branch (flush) and its target
//   halt_in             presented instruction is the stop instruction
//   imem_en/addr/rdata  instruction-memory read port
//   pc, inst, valid     instruction presented to decode
//   running             fetch state machine is in RUN
//
// Optional build macro FETCH_PERF_EN adds the perf_fetched and perf_bubbles
// saturating counters and their output ports.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               dec_redirect,
  input  logic [31:0]        dec_npc,
  input  logic               ex_redirect,
  input  logic [31:0]        ex_target,
  input  logic               halt_in,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        inst,
  output logic               valid,
  output logic               running
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] pc_q;
  logic        inflight;
  logic        squash;
  logic [31:0] skid;
  logic        skid_v;

  logic        run;
  logic        valid_c;
  logic        ex_take;
  logic        dec_take;
  logic        halt_take;
  logic        issue_en;
  logic        issue;

  // Low address bits are forced to word alignment and the upper fetch_pc
  // bits only matter for the architectural pc, not the memory address.
  logic        unused_bits;
  assign unused_bits = ^{dec_npc[1:0], ex_target[1:0], fetch_pc};

  assign run       = (state == S_RUN);
  // An execute flush kills the presented instruction in the same cycle.
  assign valid_c   = (inflight | skid_v) & ~squash & ~ex_redirect;
  assign ex_take   = ex_redirect & run;
  assign dec_take  = dec_redirect & valid_c & ~stall;
  assign halt_take = halt_in & valid_c & ~stall;
  // The memory is read whenever fetch may advance; on a redirect cycle that
  // read is on the wrong path and is tagged by squash instead of presented.
  assign issue_en  = run & ~stall & ~halt_take;
  assign issue     = issue_en & ~ex_take & ~dec_take;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: HALT is only left through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_take) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode towards memory and decode.
  always_comb begin
    running   = run;
    imem_en   = issue_en;
    imem_addr = fetch_pc[IMEM_AW+1:2];
    valid     = valid_c;
    pc        = pc_q;
    // imem_rdata is only meaningful the cycle after a read; show zero otherwise.
    if (skid_v) begin
      inst = skid;
    end else if (inflight) begin
      inst = imem_rdata;
    end else begin
      inst = 32'h0000_0000;
    end
  end

  // Fetch address and presented-pc registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pc_q     <= 32'h0000_0000;
    end else begin
      if (ex_take) begin
        fetch_pc <= {ex_target[31:2], 2'b00};
      end else if (dec_take) begin
        fetch_pc <= {dec_npc[31:2], 2'b00};
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end else begin
        fetch_pc <= fetch_pc;
      end
      if (issue) begin
        pc_q <= fetch_pc;
      end else begin
        pc_q <= pc_q;
      end
    end
  end

  // In-flight read tracking; a stall holds the outstanding read as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else if (!run) begin
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else if (stall && !ex_take) begin
      inflight <= inflight;
      squash   <= squash;
    end else begin
      inflight <= issue_en;
      squash   <= issue_en & (ex_take | dec_take);
    end
  end

  // Skid register: capture the returning word on the first stall cycle so the
  // presented instruction survives the memory output going stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid   <= 32'h0000_0000;
      skid_v <= 1'b0;
    end else if (!run || ex_take) begin
      skid   <= skid;
      skid_v <= 1'b0;
    end else if (stall) begin
      if (inflight && !skid_v) begin
        skid   <= imem_rdata;
        skid_v <= 1'b1;
      end else begin
        skid   <= skid;
        skid_v <= skid_v;
      end
    end else begin
      skid   <= skid;
      skid_v <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating performance counters, active only in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0000_0000;
      perf_bubbles <= 32'h0000_0000;
    end else if (run) begin
      if (valid_c && !stall && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end else begin
        perf_fetched <= perf_fetched;
      end
      if (!valid_c && (perf_bubbles != 32'hFFFF_FFFF)) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end else begin
        perf_bubbles <= perf_bubbles;
      end
    end else begin
      perf_fetched <= perf_fetched;
      perf_bubbles <= perf_bubbles;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// The memory model returns word k = k one cycle after a read and drives
// 32'hDEADBEEF after cycles with no read. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        dec_redirect;
  logic [31:0] dec_npc;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        halt_in;
  logic        imem_en;
  logic [14:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;
  logic        running;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .dec_redirect (dec_redirect),
    .dec_npc      (dec_npc),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .halt_in      (halt_in),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .inst         (inst),
    .valid        (valid),
    .running      (running)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  // Synchronous-read instruction memory: word k holds k.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= {17'd0, imem_addr};
    else         imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_in();
    start = 1'b0; stall = 1'b0; dec_redirect = 1'b0; dec_npc = 32'h0;
    ex_redirect = 1'b0; ex_target = 32'h0; halt_in = 1'b0;
  endtask

  // Reset, pulse start in cycle 0, return at the input point of cycle 2.
  task automatic restart();
    clear_in();
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0; start = 1'b1;
    nxt();
    start = 1'b0;
    nxt();
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  initial begin
    imem_rdata = 32'h0;
    clear_in();

    // Reset state
    rst = 1'b1;
    nxt(); nxt();
    settle();
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_en", {31'd0, imem_en}, 32'd0);
    check_val("rst_pc", pc, 32'd0);
    check_val("rst_inst", inst, 32'd0);
    check_val("rst_running", {31'd0, running}, 32'd0);

    // Straight line and start latency
    nxt();
    rst = 1'b0; start = 1'b1;
    settle();
    check_val("c0_running", {31'd0, running}, 32'd0);
    nxt();
    start = 1'b0;
    settle();
    check_val("c1_running", {31'd0, running}, 32'd1);
    check_val("c1_valid", {31'd0, valid}, 32'd0);
    check_val("c1_en", {31'd0, imem_en}, 32'd1);
    check_val("c1_addr", {17'd0, imem_addr}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      nxt(); settle();
      check_val("line_valid", {31'd0, valid}, 32'd1);
      check_val("line_pc", pc, 32'(4 * k));
      check_val("line_inst", inst, 32'(k));
    end

    // Stall hold at pc=8 for three cycles
    nxt();
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      settle();
      check_val("stall_valid", {31'd0, valid}, 32'd1);
      check_val("stall_pc", pc, 32'd8);
      check_val("stall_inst", inst, 32'd2);
      check_val("stall_en", {31'd0, imem_en}, 32'd0);
      nxt();
    end
    stall = 1'b0;
    settle();
    check_val("rel_pc", pc, 32'd8);
    check_val("rel_inst", inst, 32'd2);
    check_val("rel_en", {31'd0, imem_en}, 32'd1);
    nxt(); settle();
    check_val("after_pc", pc, 32'd12);
    check_val("after_inst", inst, 32'd3);
    check_val("after_valid", {31'd0, valid}, 32'd1);

    // Decode jump at pc=4
    restart();
    nxt();
    dec_redirect = 1'b1; dec_npc = 32'h0000_0103;
    settle();
    check_val("dj_pc", pc, 32'd4);
    check_val("dj_valid", {31'd0, valid}, 32'd1);
    nxt();
    dec_redirect = 1'b0; dec_npc = 32'h0;
    settle();
    check_val("dj_bubble", {31'd0, valid}, 32'd0);
    nxt(); settle();
    check_val("dj_t_valid", {31'd0, valid}, 32'd1);
    check_val("dj_t_pc", pc, 32'h100);
    check_val("dj_t_inst", inst, 32'h40);
    nxt(); settle();
    check_val("dj_t4_pc", pc, 32'h104);
    check_val("dj_t4_inst", inst, 32'h41);

    // Execute flush at pc=16 with concurrent decode redirect and stall
    restart();
    adv(4);
    ex_redirect = 1'b1; ex_target = 32'h0000_0040;
    dec_redirect = 1'b1; dec_npc = 32'h0000_0200; stall = 1'b1;
    settle();
    check_val("ex_pc_seen", pc, 32'd16);
    check_val("ex_valid", {31'd0, valid}, 32'd0);
    nxt();
    clear_in();
    settle();
    check_val("ex_bubble", {31'd0, valid}, 32'd0);
    nxt(); settle();
    check_val("ex_t_valid", {31'd0, valid}, 32'd1);
    check_val("ex_t_pc", pc, 32'h40);
    check_val("ex_t_inst", inst, 32'h10);
    nxt(); settle();
    check_val("ex_t4_pc", pc, 32'h44);

    // Halt at pc=20
    restart();
    adv(5);
    halt_in = 1'b1;
    settle();
    check_val("halt_valid", {31'd0, valid}, 32'd1);
    check_val("halt_pc", pc, 32'd20);
    check_val("halt_en", {31'd0, imem_en}, 32'd0);
    nxt();
    halt_in = 1'b0; start = 1'b1;
    settle();
    check_val("halted_valid", {31'd0, valid}, 32'd0);
    check_val("halted_en", {31'd0, imem_en}, 32'd0);
    check_val("halted_run", {31'd0, running}, 32'd0);
    nxt();
    start = 1'b0;
    nxt(); settle();
    check_val("halted2_valid", {31'd0, valid}, 32'd0);
    check_val("halted2_en", {31'd0, imem_en}, 32'd0);
    check_val("halted2_run", {31'd0, running}, 32'd0);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    settle();
    check_val("hrst_pc", pc, 32'd0);
    check_val("hrst_valid", {31'd0, valid}, 32'd0);

    // Reset during a held stall with the skid register full
    restart();
    nxt();
    stall = 1'b1;
    settle();
    check_val("rs_pc", pc, 32'd4);
    nxt();
    rst = 1'b1;
    settle();
    check_val("rs_skid_inst", inst, 32'd1);
    check_val("rs_skid_valid", {31'd0, valid}, 32'd1);
    nxt();
    rst = 1'b0; stall = 1'b0;
    settle();
    check_val("rs_valid", {31'd0, valid}, 32'd0);
    check_val("rs_run", {31'd0, running}, 32'd0);
`ifdef FETCH_PERF_EN
    check_val("rs_perf_f", perf_fetched, 32'd0);
    check_val("rs_perf_b", perf_bubbles, 32'd0);
`endif
    nxt();
    start = 1'b1;
    nxt();
    start = 1'b0;
    nxt(); settle();
    check_val("rs_re_valid", {31'd0, valid}, 32'd1);
    check_val("rs_re_pc", pc, 32'd0);
    check_val("rs_re_inst", inst, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
